// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-master, one-slave round-robin bus arbiter.
// Ports: clk/resetn; m0_*/m1_* req/ack masters; s_* slave; bus_err.
//   Masters hold req+payload until a one-cycle mN_ack; rdata is valid with ack.
//   Slave sees a one-cycle s_req with registered payload, answers with s_ack.
//   ARB_TIMEOUT_EN (macro): ack timeout after TIMEOUT cycles, sticky bus_err.
module soc_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  pick0;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (CW > 8) ? CW : 8;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  tmo;

  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  // Master 0 wins unless only m1 asks, or both ask and m0 went last.
  assign pick0 = m0_req & (~m1_req | last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          gnt_d   = ~pick0;
          last_d  = ~pick0;
          we_d    = pick0 ? m0_we    : m1_we;
          addr_d  = pick0 ? m0_addr  : m1_addr;
          wdata_d = pick0 ? m0_wdata : m1_wdata;
          wmask_d = pick0 ? m0_wmask : m1_wmask;
          state_d = ISSUE;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE, WAIT: begin
        if (s_ack) begin
          rdata_d = s_rdata;
          state_d = DONE;
`ifdef ARB_TIMEOUT_EN
        end else if (tmo) begin
          rdata_d = '1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT;
`else
        end else begin
          state_d = WAIT;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Strobes decode straight from the state register so reset kills them at once.
  assign s_req    = (state_q == ISSUE);
  assign m0_ack   = (state_q == DONE) & ~gnt_q;
  assign m1_ack   = (state_q == DONE) &  gnt_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign s_we     = we_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wmask  = wmask_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb_soc_bus_arbiter: directed vector bench for soc_bus_arbiter.
// Table of transactions plus reset-in-WAIT and timeout sequences.
module tb_soc_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        m0_req = 0, m0_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic [3:0]  m0_wmask = 0;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req = 0, m1_we = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m1_wmask = 0;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wmask;
  logic        s_ack = 0;
  logic [31:0] s_rdata = 0;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  soc_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_ack(s_ack), .s_rdata(s_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        r0, r1;
    logic        we0;
    logic [31:0] a0, d0;
    logic [3:0]  k0;
    logic        we1;
    logic [31:0] a1, d1;
    logic [3:0]  k1;
    int          lat;
    logic [31:0] srd;
    int          em;
    logic        ewe;
    logic [31:0] ea, ed;
    logic [3:0]  ek;
    int          et;
    logic        crd;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".s_req"}, {31'd0, s_req}, 0);
    chk({tag, ".s_we"}, {31'd0, s_we}, 0);
    chk({tag, ".s_addr"}, s_addr, 0);
    chk({tag, ".s_wdata"}, s_wdata, 0);
    chk({tag, ".s_wmask"}, {28'd0, s_wmask}, 0);
    chk({tag, ".acks"}, {30'd0, m1_ack, m0_ack}, 0);
    chk({tag, ".m0_rdata"}, m0_rdata, 0);
    chk({tag, ".m1_rdata"}, m1_rdata, 0);
    chk({tag, ".bus_err"}, {31'd0, bus_err}, 0);
  endtask

  function automatic vec_t mk(
    input logic r0, r1, we0, input logic [31:0] a0, d0,
    input logic [3:0] k0, input logic we1, input logic [31:0] a1, d1,
    input logic [3:0] k1, input int lat, input logic [31:0] srd,
    input int em, input logic ewe, input logic [31:0] ea, ed,
    input logic [3:0] ek, input int et, input logic crd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.k0 = k0; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.k1 = k1;
    v.lat = lat; v.srd = srd; v.em = em; v.ewe = ewe;
    v.ea = ea; v.ed = ed; v.ek = ek; v.et = et; v.crd = crd;
    return v;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    int  issue_t;
    int  pulses;
    int  ack_t;
    bit  done;
    string tg;
    tg = $sformatf("v%0d", n);
    issue_t = 0;
    pulses = 0;
    ack_t = 0;
    done = 0;
    @(posedge clk);
    #1;
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0;
    m0_wdata = v.d0; m0_wmask = v.k0;
    m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1;
    m1_wdata = v.d1; m1_wmask = v.k1;
    s_rdata = v.srd;
    for (int t = 1; t <= 60 && !done; t++) begin
      @(posedge clk);
      #1;
      if (s_req) begin
        pulses++;
        if (issue_t == 0) begin
          issue_t = t;
          chk({tg, ".s_addr"}, s_addr, v.ea);
          chk({tg, ".s_we"}, {31'd0, s_we}, {31'd0, v.ewe});
          chk({tg, ".s_wdata"}, s_wdata, v.ed);
          chk({tg, ".s_wmask"}, {28'd0, s_wmask}, {28'd0, v.ek});
        end
      end
      s_ack = (issue_t > 0) && (t == issue_t + v.lat);
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        ack_t = t;
        done = 1;
        chk({tg, ".ack_sel"}, {30'd0, m1_ack, m0_ack},
            (v.em == 0) ? 32'd1 : 32'd2);
        chk({tg, ".ack_cycle"}, ack_t, v.et);
        if (v.crd)
          chk({tg, ".rdata"}, (v.em == 0) ? m0_rdata : m1_rdata, v.srd);
      end
    end
    if (!done)
      chk({tg, ".ack_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    s_ack = 0;
    m0_req = 0;
    m1_req = 0;
    @(negedge clk);
    chk({tg, ".ack_one_cycle"}, {30'd0, m1_ack, m0_ack}, 0);
    chk({tg, ".s_req_pulses"}, pulses, 1);
  endtask

  initial begin
    vt[0] = mk(1, 1, 0, 32'h100, 32'h11, 4'hF, 0, 32'h200, 32'h22, 4'h3,
               1, 32'hA0A0_0001, 0, 0, 32'h100, 32'h11, 4'hF, 3, 1);
    vt[1] = mk(1, 1, 0, 32'h100, 32'h11, 4'hF, 0, 32'h200, 32'h22, 4'h3,
               1, 32'hB0B0_0002, 1, 0, 32'h200, 32'h22, 4'h3, 3, 1);
    vt[2] = mk(1, 1, 0, 32'h100, 32'h11, 4'hF, 0, 32'h200, 32'h22, 4'h3,
               1, 32'hC0C0_0003, 0, 0, 32'h100, 32'h11, 4'hF, 3, 1);
    vt[3] = mk(1, 1, 0, 32'h100, 32'h11, 4'hF, 0, 32'h200, 32'h22, 4'h3,
               1, 32'hD0D0_0004, 1, 0, 32'h200, 32'h22, 4'h3, 3, 1);
    vt[4] = mk(1, 0, 0, 32'h10, 32'h0, 4'h0, 0, 32'h0, 32'h0, 4'h0,
               1, 32'h1234_5678, 0, 0, 32'h10, 32'h0, 4'h0, 3, 1);
    vt[5] = mk(0, 1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0040_0004,
               32'h0000_003F, 4'h1, 1, 32'hDEAD_BEEF, 1, 1,
               32'h0040_0004, 32'h3F, 4'h1, 3, 0);
    vt[6] = mk(1, 0, 0, 32'h20, 32'h5, 4'h2, 0, 32'h0, 32'h0, 4'h0,
               7, 32'h0BAD_F00D, 0, 0, 32'h20, 32'h5, 4'h2, 9, 1);
    vt[7] = mk(1, 0, 0, 32'h30, 32'h6, 4'h4, 0, 32'h0, 32'h0, 4'h0,
               0, 32'h5555_AAAA, 0, 0, 32'h30, 32'h6, 4'h4, 2, 1);
    vt[8] = mk(1, 0, 0, 32'h50, 32'h7, 4'h8, 0, 32'h0, 32'h0, 4'h0,
               1, 32'h0000_7777, 0, 0, 32'h50, 32'h7, 4'h8, 3, 1);
    vt[9] = mk(1, 0, 0, 32'h70, 32'h8, 4'hF, 0, 32'h0, 32'h0, 4'h0,
               2, 32'h0000_0001, 0, 0, 32'h70, 32'h8, 4'hF, 4, 1);

    #1 resetn = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++)
      run_vec(i, vt[i]);

    // Reset while parked in WAIT with a non-zero payload registered.
    @(posedge clk);
    #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h44;
    m0_wdata = 32'h99; m0_wmask = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midwait.s_addr", s_addr, 32'h44);
    #2 resetn = 1'b0;
    #1 chk_zero("midwait");
    m0_req = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1 s_ack = 1;
    @(posedge clk);
    #1 s_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_ack", {30'd0, m1_ack, m0_ack}, 0);
    end
    run_vec(8, vt[8]);

`ifdef ARB_TIMEOUT_EN
    begin
      int at;
      at = 0;
      @(posedge clk);
      #1;
      m0_req = 1; m0_we = 0; m0_addr = 32'h60;
      for (int t = 1; t <= 40 && at == 0; t++) begin
        @(negedge clk);
        if (m0_ack) begin
          at = t;
          chk("tmo.rdata", m0_rdata, 32'hFFFF_FFFF);
          chk("tmo.bus_err", {31'd0, bus_err}, 1);
        end
      end
      chk("tmo.ack_cycle", at, 17);
      @(posedge clk);
      #1 m0_req = 0;
      run_vec(9, vt[9]);
      chk("tmo.sticky", {31'd0, bus_err}, 1);
    end
`else
    run_vec(9, vt[9]);
    chk("bus_err_tied", {31'd0, bus_err}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
